pedal_chain: RTL and testbench

Parametrised effect-chain sequencer: the next generation of the fixed overdrive/tremolo pedal board. It accepts one audio sample per `Sample_valid` pulse and walks it through `SLOTS` effect slots in order. For each enabled slot it runs a START/DONE handshake; disabled slots are bypassed. The final sample is presented with a one-cycle `Out_valid` strobe. It sits between the codec receive path and the codec transmit path, and replaces the hard-wired mux chain.

---
 rtl/pedal_chain_if.sv | 40 ++++
 rtl/pedal_chain.sv | 184 ++++++++++++++++++
 tb/tb_pedal_chain.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pedal_chain_if.sv
// pedal_chain_if: sample, status and effect-slot bus of the pedal_chain sequencer.
// Latency: none, wires only.
// Backpressure: none; samples that arrive while the sequencer is busy are dropped and flagged.
//
// Signals:
//   Sample_in/Sample_valid/Enable/Clear_flags: codec receive side and switch bank into the sequencer.
//   Fx_in/Fx_start: sequencer out to the effect slots.
//   Fx_done/Fx_out: effect slots back to the sequencer.
//   Signal_out/Out_valid/Busy/Overrun/Timeout_flag: sequencer out to the codec transmit side.
// Modports:
//   master: the sequencer.
//   slave:  everything around it (codec paths, switch bank, effect slots).
interface pedal_chain_if #(
    parameter int WIDTH = 16,
    parameter int SLOTS = 4
);
    logic [WIDTH-1:0]       Sample_in;
    logic                   Sample_valid;
    logic [SLOTS-1:0]       Enable;
    logic                   Clear_flags;
    logic [WIDTH-1:0]       Fx_in;
    logic [SLOTS-1:0]       Fx_start;
    logic [SLOTS-1:0]       Fx_done;
    logic [SLOTS*WIDTH-1:0] Fx_out;
    logic [WIDTH-1:0]       Signal_out;
    logic                   Out_valid;
    logic                   Busy;
    logic                   Overrun;
    logic                   Timeout_flag;

    modport master (
        input  Sample_in, Sample_valid, Enable, Clear_flags, Fx_done, Fx_out,
        output Fx_in, Fx_start, Signal_out, Out_valid, Busy, Overrun, Timeout_flag
    );

    modport slave (
        output Sample_in, Sample_valid, Enable, Clear_flags, Fx_done, Fx_out,
        input  Fx_in, Fx_start, Signal_out, Out_valid, Busy, Overrun, Timeout_flag
    );
endinterface

// File: rtl/pedal_chain.sv
// pedal_chain: walks one sample through SLOTS effect slots via START/DONE, bypassing disabled slots.
// Latency: SLOTS+2 cycles plus (1+Dk) for each enabled slot k (Dk = cycles until slot k's DONE).
// Backpressure: none; a sample arriving while Busy is dropped and sets the sticky Overrun flag.
//
// Ports:
//   Clk, Reset (async, active-low)
//   bus (pedal_chain_if.master): sample input, Enable switch bank, Clear_flags, shared Fx_in bus,
//     per-slot Fx_start/Fx_done/Fx_out, Signal_out/Out_valid, Busy, Overrun, Timeout_flag.
// Optional feature: define PEDAL_TIMEOUT_EN to abandon a slot after TIMEOUT WAIT cycles.
// Without it the timeout counter is not built and Timeout_flag is tied 0.
module pedal_chain #(
    parameter int WIDTH   = 16,
    parameter int SLOTS   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          Clk,
    input  logic          Reset,
    pedal_chain_if.master bus
);
    localparam int IW = $clog2(SLOTS + 1);
    localparam logic [IW-1:0] IDX_END = IW'(SLOTS);

    if (SLOTS < 1 || SLOTS > 16 || TIMEOUT < 1) begin : g_bad_cfg
        $error("pedal_chain: SLOTS must be 1..16 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, OUT} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] sig_out_q, sig_out_d;
    logic [SLOTS-1:0] en_q, en_d;
    logic [SLOTS-1:0] start_q, start_d;
    logic             out_vld_q, out_vld_d;
    logic             overrun_q, overrun_d;

`ifdef PEDAL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    // Counter value on the last WAIT cycle allowed before the slot is abandoned.
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             tflag_q, tflag_d;
`endif

    // One-hot decode of idx so the current slot's enable, DONE and result are picked
    // without indexing past the switch bank when idx has reached SLOTS.
    logic [SLOTS-1:0] sel;
    logic             en_sel;
    logic             done_sel;
    logic [WIDTH-1:0] res_sel;

    always_comb begin
        sel     = '0;
        res_sel = '0;
        for (int k = 0; k < SLOTS; k++) begin
            sel[k] = (idx_q == IW'(k));
            if (sel[k]) begin
                res_sel = bus.Fx_out[k*WIDTH +: WIDTH];
            end
        end
        en_sel   = |(en_q & sel);
        done_sel = |(bus.Fx_done & sel);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        en_d      = en_q;
        start_d   = start_q;
        sig_out_d = sig_out_q;
        out_vld_d = 1'b0;

        // Sticky flags: a set event in the same cycle overrides a clear.
        overrun_d = overrun_q;
        if (bus.Clear_flags) begin
            overrun_d = 1'b0;
        end
        if (bus.Sample_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
`ifdef PEDAL_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        tflag_d = tflag_q;
        if (bus.Clear_flags) begin
            tflag_d = 1'b0;
        end
`endif

        case (state_q)
            IDLE: begin
                if (bus.Sample_valid) begin
                    data_d  = bus.Sample_in;
                    en_d    = bus.Enable;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (idx_q == IDX_END) begin
                    state_d = OUT;
                end else if (en_sel) begin
                    start_d = sel;
`ifdef PEDAL_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                    state_d = WAIT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            WAIT: begin
                // START stays high until DONE is seen; DONE wins over an expiring timeout.
                if (done_sel) begin
                    data_d  = res_sel;
                    start_d = '0;
                    idx_d   = idx_q + IW'(1);
                    state_d = SCAN;
                end
`ifdef PEDAL_TIMEOUT_EN
                else if (tcnt_q == TLAST) begin
                    start_d = '0;
                    tflag_d = 1'b1;
                    idx_d   = idx_q + IW'(1);
                    state_d = SCAN;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
`endif
            end
            OUT: begin
                sig_out_d = data_q;
                out_vld_d = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            en_q      <= '0;
            start_q   <= '0;
            sig_out_q <= '0;
            out_vld_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PEDAL_TIMEOUT_EN
            tcnt_q    <= '0;
            tflag_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            en_q      <= en_d;
            start_q   <= start_d;
            sig_out_q <= sig_out_d;
            out_vld_q <= out_vld_d;
            overrun_q <= overrun_d;
`ifdef PEDAL_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
            tflag_q   <= tflag_d;
`endif
        end
    end

    assign bus.Fx_in      = data_q;
    assign bus.Fx_start   = start_q;
    assign bus.Signal_out = sig_out_q;
    assign bus.Out_valid  = out_vld_q;
    assign bus.Busy       = (state_q != IDLE);
    assign bus.Overrun    = overrun_q;
`ifdef PEDAL_TIMEOUT_EN
    assign bus.Timeout_flag = tflag_q;
`else
    assign bus.Timeout_flag = 1'b0;
`endif
endmodule

// File: tb/tb_pedal_chain.sv
// tb_pedal_chain: directed plus randomized samples through pedal_chain, compared to a reference chain model.
// Latency: expected Out_valid latency derived from the enable pattern and each slot's DONE delay.
// Backpressure: slot models hold DONE until START falls; overrun samples are injected while busy.
module tb_pedal_chain;
    localparam int WIDTH   = 16;
    localparam int SLOTS   = 4;
    localparam int TIMEOUT = 8;
    localparam int HUNG    = 100000;
`ifdef PEDAL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    pedal_chain_if #(.WIDTH(WIDTH), .SLOTS(SLOTS)) bus ();

    pedal_chain #(.WIDTH(WIDTH), .SLOTS(SLOTS), .TIMEOUT(TIMEOUT)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int               n_checks = 0;
    int               n_pass   = 0;
    int               slot_dly [SLOTS];
    int               slot_cnt [SLOTS];
    int               start_log [$];
    bit               overlap_seen;
    logic [SLOTS-1:0] prev_start;
    logic             exp_overrun;
    logic             exp_tflag;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Behaviour of each effect slot.
    function automatic logic [WIDTH-1:0] slot_fn(input int k, input logic [WIDTH-1:0] x);
        case (k % 4)
            0:       return x + 16'd1;
            1:       return x ^ 16'h5A5A;
            2:       return x << 1;
            default: return x - 16'd3;
        endcase
    endfunction

    // A slot whose DONE would first be sampled after TIMEOUT WAIT cycles gets abandoned.
    function automatic bit slot_times_out(input int k);
        return TMO_EN && (slot_dly[k] >= TIMEOUT);
    endfunction

    // Effect slot models: DONE rises slot_dly cycles after START, held until START falls.
    initial begin
        prev_start = '0;
        for (int k = 0; k < SLOTS; k++) slot_cnt[k] = 0;
        forever begin
            @(negedge Clk);
            if ($countones(bus.Fx_start) > 1) overlap_seen = 1'b1;
            for (int k = 0; k < SLOTS; k++) begin
                if (bus.Fx_start[k] && !prev_start[k]) start_log.push_back(k);
                if (bus.Fx_start[k]) slot_cnt[k]++;
                else slot_cnt[k] = 0;
                bus.Fx_done[k] = bus.Fx_start[k] && (slot_cnt[k] > slot_dly[k]);
                bus.Fx_out[k*WIDTH +: WIDTH] = slot_fn(k, bus.Fx_in);
            end
            prev_start = bus.Fx_start;
        end
    end

    // Feeds one sample; en_late replaces the switch bank mid-sample, poke injects an overrun sample.
    task automatic run_sample(input logic [WIDTH-1:0] s, input logic [SLOTS-1:0] en,
                              input logic [SLOTS-1:0] en_late, input bit poke, input bit poke_clr);
        logic [WIDTH-1:0] exp_out;
        int               exp_lat;
        int               exp_order [$];
        int               lat;
        bit               got;
        exp_out = s;
        exp_lat = SLOTS + 2;
        lat     = 0;
        got     = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            if (en[k]) begin
                exp_order.push_back(k);
                if (slot_times_out(k)) begin
                    exp_lat  += TIMEOUT;
                    exp_tflag = 1'b1;
                end else begin
                    exp_lat += 1 + slot_dly[k];
                    exp_out  = slot_fn(k, exp_out);
                end
            end
        end
        start_log.delete();
        overlap_seen = 1'b0;

        bus.Sample_in    = s;
        bus.Enable       = en;
        bus.Sample_valid = 1'b1;
        @(posedge Clk); #1;
        bus.Sample_valid = 1'b0;
        bus.Sample_in    = WIDTH'($urandom);
        check_val("busy_after_capture", 32'(bus.Busy), 32'd1);

        while (!got && lat < 4000) begin
            @(posedge Clk); #1;
            lat++;
            if (lat == 2) begin
                bus.Enable = en_late;
                if (poke) begin
                    bus.Sample_valid = 1'b1;
                    bus.Sample_in    = ~s;
                    bus.Clear_flags  = poke_clr;
                    exp_overrun      = 1'b1;
                end
            end
            if (lat == 3) begin
                bus.Sample_valid = 1'b0;
                bus.Clear_flags  = 1'b0;
            end
            if (bus.Out_valid) got = 1'b1;
        end

        check_val("out_valid_seen", 32'(got), 32'd1);
        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("signal_out", 32'(bus.Signal_out), 32'(exp_out));
        check_val("busy_at_out", 32'(bus.Busy), 32'd0);
        check_val("start_overlap", 32'(overlap_seen), 32'd0);
        check_val("start_count", 32'(start_log.size()), 32'(exp_order.size()));
        for (int i = 0; i < exp_order.size() && i < start_log.size(); i++)
            check_val("start_order", 32'(start_log[i]), 32'(exp_order[i]));
        check_val("overrun", 32'(bus.Overrun), 32'(exp_overrun));
        check_val("timeout_flag", 32'(bus.Timeout_flag), 32'(exp_tflag));
        @(posedge Clk); #1;
        check_val("out_valid_pulse", 32'(bus.Out_valid), 32'd0);
    endtask

    task automatic pulse_clear();
        bus.Clear_flags = 1'b1;
        @(posedge Clk); #1;
        bus.Clear_flags = 1'b0;
        exp_overrun = 1'b0;
        exp_tflag   = 1'b0;
        check_val("overrun_cleared", 32'(bus.Overrun), 32'd0);
        check_val("tflag_cleared", 32'(bus.Timeout_flag), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_fx_start"}, 32'(bus.Fx_start), 32'd0);
        check_val({tag, "_signal_out"}, 32'(bus.Signal_out), 32'd0);
        check_val({tag, "_out_valid"}, 32'(bus.Out_valid), 32'd0);
        check_val({tag, "_busy"}, 32'(bus.Busy), 32'd0);
        check_val({tag, "_overrun"}, 32'(bus.Overrun), 32'd0);
        check_val({tag, "_timeout_flag"}, 32'(bus.Timeout_flag), 32'd0);
        check_val({tag, "_fx_in"}, 32'(bus.Fx_in), 32'd0);
    endtask

    initial begin
        logic [SLOTS-1:0] en_r;
        logic [SLOTS-1:0] en_l;
        bit               poke;
        bit               poke_clr;
        bit               ov_seen;

        bus.Sample_in    = '0;
        bus.Sample_valid = 1'b0;
        bus.Enable       = '0;
        bus.Clear_flags  = 1'b0;
        exp_overrun      = 1'b0;
        exp_tflag        = 1'b0;
        for (int k = 0; k < SLOTS; k++) slot_dly[k] = 0;

        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Reset = 1'b1;
        @(posedge Clk); #1;

        // All slots bypassed.
        run_sample(16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Two-slot chain: slot 0 (+1, D=3) then slot 2 (x2, D=1).
        slot_dly[0] = 3;
        slot_dly[2] = 1;
        run_sample(16'h0010, 4'b0101, 4'b0101, 1'b0, 1'b0);

        // Switch bank moves mid-sample; only the next sample sees it.
        run_sample(16'h0777, 4'b0001, 4'b1111, 1'b0, 1'b0);
        run_sample(16'h0777, 4'b1111, 4'b1111, 1'b0, 1'b0);

        // Overrun, then clear; then clear colliding with a new overrun.
        run_sample(16'h4321, 4'b0110, 4'b0110, 1'b1, 1'b0);
        pulse_clear();
        run_sample(16'h8000, 4'b1001, 4'b1001, 1'b1, 1'b1);
        pulse_clear();

`ifdef PEDAL_TIMEOUT_EN
        // Slot 1 never answers.
        slot_dly[1] = HUNG;
        run_sample(16'h00AA, 4'b0010, 4'b0010, 1'b0, 1'b0);
        slot_dly[1] = 2;
        pulse_clear();
`endif

        // Reset while slot 0 is in WAIT.
        slot_dly[0]      = 20;
        bus.Sample_in    = 16'hBEEF;
        bus.Enable       = 4'b0001;
        bus.Sample_valid = 1'b1;
        @(posedge Clk); #1;
        bus.Sample_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        check_val("start_before_reset", 32'(bus.Fx_start), 32'd1);
        Reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_overrun = 1'b0;
        exp_tflag   = 1'b0;
        @(posedge Clk); #1;
        Reset   = 1'b1;
        ov_seen = 1'b0;
        repeat (30) begin
            @(posedge Clk); #1;
            if (bus.Out_valid) ov_seen = 1'b1;
        end
        check_val("no_out_after_reset", 32'(ov_seen), 32'd0);
        slot_dly[0] = 2;
        run_sample(16'hBEEF, 4'b0001, 4'b0001, 1'b0, 1'b0);

        // Randomized samples, switch patterns, slot delays and overrun pokes.
        for (int it = 0; it < 30; it++) begin
            en_r = SLOTS'($urandom);
            en_l = SLOTS'($urandom);
            for (int k = 0; k < SLOTS; k++) slot_dly[k] = int'($urandom_range(0, 4));
            poke     = ($urandom_range(0, 3) == 0);
            poke_clr = poke && ($urandom_range(0, 1) == 1);
            run_sample(WIDTH'($urandom), en_r, en_l, poke, poke_clr);
            if ($urandom_range(0, 4) == 0) pulse_clear();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
